// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;
  localparam int PC_STEP = 2;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WRITE   = 3'd4,
    CHECK   = 3'd5,
    RUN     = 3'd6,
    ERR     = 3'd7
  } loader_state_t;

  // States in which the loader takes a byte from the upstream stream.
  function automatic logic state_accepts(input loader_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/loader_byte_assembler.sv
// Byte-pair assembler and running XOR checksum for the program loader.
// The high byte is held in a register; the low byte is taken straight from
// the stream so the full 16-bit value is available on the accepting edge.
module loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_accept,
  input  logic               i_sel_hi,
  input  logic               i_sum_en,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic [BYTE_W-1:0]  o_checksum
);

  logic [BYTE_W-1:0] r_hi;
  logic [BYTE_W-1:0] r_sum;

  // Capture the high byte and fold every summed byte into the XOR.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_hi  <= '0;
      r_sum <= '0;
    end else if (i_accept) begin
      if (i_sel_hi) begin
        r_hi <= i_byte;
      end
      if (i_sum_en) begin
        r_sum <= r_sum ^ i_byte;
      end
    end
  end

  // Present the assembled pair and the running checksum.
  always_comb begin
    o_word     = {r_hi, i_byte};
    o_checksum = r_sum;
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte image, writes
// 16-bit words to instruction memory, verifies an XOR checksum and only then
// releases the core.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte; range-checks the count
// DATA_HI | waiting for high byte of next instruction word
// DATA_LO | waiting for low byte of next instruction word
// WRITE   | one-cycle instruction-memory write, then address/count advance
// CHECK   | waiting for checksum byte
// RUN     | load clean, core released (terminal until reset)
// ERR     | load rejected, core held (terminal until reset)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                MAX_WORDS = 256
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_byte_valid,
  input  logic [BYTE_W-1:0]  i_byte_data,
  output logic               o_byte_ready,
  output logic               o_imem_we,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_cpu_run,
  output logic               o_load_error,
  output logic [15:0]        o_words_loaded
);

  // One extra bit so MAX_WORDS up to 65535 still compares correctly.
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  loader_state_t r_state;
  loader_state_t w_state_next;

  logic [15:0]        r_len;
  logic [ADDR_W-1:0]  r_addr;
  logic [15:0]        r_words;
  logic               r_imem_we;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic               r_byte_ready;

  logic               w_accept;
  logic               w_sel_hi;
  logic               w_sum_en;
  logic [INSTR_W-1:0] w_asm_word;
  logic [BYTE_W-1:0]  w_checksum;
  logic [15:0]        w_words_inc;
  logic               w_ready_next;
  logic               w_we_next;

  // Ready is registered from the next state, so it is a pure function of
  // state and stays low while reset is held.
  assign w_accept    = i_byte_valid & r_byte_ready;
  assign w_sel_hi    = (r_state == LEN_HI) || (r_state == DATA_HI);
  assign w_sum_en    = (r_state != CHECK);
  assign w_words_inc = r_words + 16'd1;

  loader_byte_assembler u_asm (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_accept   (w_accept),
    .i_sel_hi   (w_sel_hi),
    .i_sum_en   (w_sum_en),
    .i_byte     (i_byte_data),
    .o_word     (w_asm_word),
    .o_checksum (w_checksum)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= LEN_HI;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LEN_HI: begin
        if (w_accept) begin
          w_state_next = LEN_LO;
        end
      end
      LEN_LO: begin
        if (w_accept) begin
          if ({1'b0, w_asm_word} > MAX_LEN) begin
            w_state_next = ERR;
          end else if (w_asm_word == 16'd0) begin
            w_state_next = CHECK;
          end else begin
            w_state_next = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (w_accept) begin
          w_state_next = DATA_LO;
        end
      end
      DATA_LO: begin
        if (w_accept) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        if (w_words_inc == r_len) begin
          w_state_next = CHECK;
        end else begin
          w_state_next = DATA_HI;
        end
      end
      CHECK: begin
        if (w_accept) begin
          if (i_byte_data == w_checksum) begin
            w_state_next = RUN;
          end else begin
            w_state_next = ERR;
          end
        end
      end
      RUN:     w_state_next = RUN;
      ERR:     w_state_next = ERR;
      default: w_state_next = ERR;
    endcase
  end

  // Output decode: registered strobes come from the next state, status
  // flags from the current state.
  always_comb begin
    w_ready_next   = state_accepts(w_state_next);
    w_we_next      = (w_state_next == WRITE);
    o_byte_ready   = r_byte_ready;
    o_imem_we      = r_imem_we;
    o_imem_addr    = r_addr;
    o_imem_wdata   = r_imem_wdata;
    o_words_loaded = r_words;
    o_cpu_run      = (r_state == RUN);
    o_load_error   = (r_state == ERR);
  end

  // Length, write data, address and word counter; address and count advance
  // as the WRITE cycle ends.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_len        <= '0;
      r_addr       <= BASE_ADDR;
      r_words      <= '0;
      r_imem_we    <= 1'b0;
      r_imem_wdata <= '0;
      r_byte_ready <= 1'b0;
    end else begin
      r_byte_ready <= w_ready_next;
      r_imem_we    <= w_we_next;
      if ((r_state == LEN_LO) && w_accept) begin
        r_len <= w_asm_word;
      end
      if ((r_state == DATA_LO) && w_accept) begin
        r_imem_wdata <= w_asm_word;
      end
      if (r_state == WRITE) begin
        r_addr  <= r_addr + ADDR_W'(PC_STEP);
        r_words <= w_words_inc;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed images plus randomized images, each
// checked against a reference model that derives writes and final status
// directly from the image bytes.
module tb_program_loader;

  localparam int          MAXW = 256;
  localparam logic [15:0] BASE = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  data;
  logic        ready;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        cpu_run;
  logic        load_err;
  logic [15:0] words;

  program_loader #(
    .ADDR_W    (16),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_byte_valid   (valid),
    .i_byte_data    (data),
    .o_byte_ready   (ready),
    .o_imem_we      (we),
    .o_imem_addr    (addr),
    .o_imem_wdata   (wdata),
    .o_cpu_run      (cpu_run),
    .o_load_error   (load_err),
    .o_words_loaded (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] cap_addr[$];
  logic [15:0] cap_data[$];
  int          gap_bad = 0;
  int          we_ready_bad = 0;
  bit          in_gap = 1'b0;
  logic [7:0]  img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every write strobe and watch ready during idle gaps.
  always @(negedge clk) begin
    if (we) begin
      cap_addr.push_back(addr);
      cap_data.push_back(wdata);
      if (ready) we_ready_bad++;
    end
    if (in_gap && !we && !ready) gap_bad++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk); #1;
    check("rst.ready", ready, 0);
    check("rst.we", we, 0);
    check("rst.addr", addr, BASE);
    check("rst.wdata", wdata, 0);
    check("rst.cpu_run", cpu_run, 0);
    check("rst.load_error", load_err, 0);
    check("rst.words", words, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.ready_after", ready, 1);
    cap_addr.delete();
    cap_data.delete();
    gap_bad = 0;
    we_ready_bad = 0;
  endtask

  // Hold one byte valid until it is taken, then idle for 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    bit got;
    bit rdy;
    got = 1'b0;
    valid = 1'b1;
    data = b;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
    end
    valid = 1'b0;
    data = 8'($urandom);
    check("accept", got, 1);
    if (!last) in_gap = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
    in_gap = 1'b0;
  endtask

  task automatic build_image(input int len, input bit good);
    logic [7:0] s;
    logic [7:0] b;
    img.delete();
    img.push_back(8'(len >> 8));
    img.push_back(8'(len));
    for (int i = 0; i < 2 * len; i++) begin
      b = 8'($urandom);
      img.push_back(b);
    end
    s = 8'h00;
    foreach (img[i]) s = s ^ img[i];
    img.push_back(good ? s : (s ^ 8'($urandom_range(1, 255))));
  endtask

  // Model: the header decides acceptance; word i lands at BASE+2i; the
  // final byte must equal the XOR of everything before it.
  task automatic run_image(input string name, input int gap_mode);
    int          len;
    int          n_send;
    logic [7:0]  s;
    bit          exp_run;
    int          exp_words;
    logic [15:0] ea[$];
    logic [15:0] ed[$];
    int          gap;
    int          n;
    len = {img[0], img[1]};
    if (len > MAXW) begin
      n_send    = 2;
      exp_run   = 1'b0;
      exp_words = 0;
    end else begin
      for (int i = 0; i < len; i++) begin
        ea.push_back(16'(BASE + 2 * i));
        ed.push_back({img[2 + 2 * i], img[3 + 2 * i]});
      end
      s = 8'h00;
      for (int i = 0; i < 2 * len + 2; i++) s = s ^ img[i];
      n_send    = 2 * len + 3;
      exp_run   = (img[2 * len + 2] == s);
      exp_words = len;
    end
    for (int k = 0; k < n_send; k++) begin
      gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      send_byte(img[k], gap, k == n_send - 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, ".cpu_run"}, cpu_run, exp_run);
    check({name, ".load_error"}, load_err, !exp_run);
    check({name, ".ready"}, ready, 0);
    check({name, ".words"}, words, exp_words);
    check({name, ".wr_count"}, cap_addr.size(), ea.size());
    n = (cap_addr.size() < ea.size()) ? cap_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", name, i), cap_addr[i], ea[i]);
      check($sformatf("%s.data%0d", name, i), cap_data[i], ed[i]);
    end
    check({name, ".we_ready"}, we_ready_bad, 0);
    check({name, ".gap_ready"}, gap_bad, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

    do_reset();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_image("nominal", 0);

    do_reset();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_image("badsum", 0);

    do_reset();
    img = '{8'h01, 8'h01};
    run_image("overflow", 0);

    do_reset();
    img = '{8'h00, 8'h00, 8'h00};
    run_image("zero", 0);

    do_reset();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_image("stall", 5);

    do_reset();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    do_reset();
    img = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    run_image("reload", 0);

    do_reset();
    build_image(MAXW, 1'b1);
    run_image("maxlen", -1);

    for (int t = 0; t < 20; t++) begin
      do_reset();
      case ($urandom_range(0, 9))
        0: begin
          img.delete();
          img.push_back(8'($urandom_range(1, 255)));
          img.push_back(8'($urandom));
        end
        1, 2:    build_image($urandom_range(0, 6), 1'b0);
        default: build_image($urandom_range(0, 8), 1'b1);
      endcase
      run_image($sformatf("rand%0d", t), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
